// File: rtl/mux_n_1_arb_v.sv
// Registered N:1 multiplexer with a valid/ready handshake on every input and
// on the output. Select is either a direct channel code or round-robin
// arbitration among the valid channels.
module mux_n_1_arb_v #(
   parameter int unsigned N_CH   = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_mode,
   input  logic [SEL_W-1:0]         i_sel_code,
   input  logic [N_CH-1:0]          i_valid,
   input  logic [N_CH*DATA_W-1:0]   i_data,
   output logic [N_CH-1:0]          o_ready,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [DATA_W-1:0]        o_code,
   output logic [SEL_W-1:0]         o_ch
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] code_q,  code_d;
   logic [SEL_W-1:0]  ch_q,    ch_d;
   logic [SEL_W-1:0]  last_gnt_q, last_gnt_d;

   logic              grant_found;
   logic [SEL_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] sel_data;
   logic              load_en;
   logic              xfer;

   // Output stage may load when empty or when its word leaves this cycle.
   assign load_en = !valid_q || i_ready;
   assign xfer    = grant_found && load_en && !i_rst;

   // Grant selection: direct code lookup, or rotating scan after last grant.
   always_comb begin
      int unsigned cand;
      grant_found = 1'b0;
      gnt_idx     = '0;
      cand        = 0;
      if (!i_mode) begin
         // Codes at or above N_CH match no channel, so they never grant.
         for (int unsigned k = 0; k < N_CH; k++) begin
            if (i_sel_code == SEL_W'(k) && i_valid[k]) begin
               grant_found = 1'b1;
               gnt_idx     = SEL_W'(k);
            end
         end
      end else begin
         for (int unsigned off = 1; off <= N_CH; off++) begin
            cand = 32'(last_gnt_q) + off;
            if (cand >= N_CH) begin
               cand = cand - N_CH;
            end
            for (int unsigned k = 0; k < N_CH; k++) begin
               if (!grant_found && k == cand && i_valid[k]) begin
                  grant_found = 1'b1;
                  gnt_idx     = SEL_W'(k);
               end
            end
         end
      end
   end

   // Data multiplexer driven by the granted index.
   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (gnt_idx == SEL_W'(k)) begin
            sel_data = i_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // One-hot accept toward the granted producer, only when a load can happen.
   always_comb begin
      o_ready = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (xfer && gnt_idx == SEL_W'(k)) begin
            o_ready[k] = 1'b1;
         end
      end
   end

   // Next state of the output stage and round-robin pointer.
   always_comb begin
      valid_d    = valid_q;
      code_d     = code_q;
      ch_d       = ch_q;
      last_gnt_d = last_gnt_q;
      if (xfer) begin
         valid_d = 1'b1;
         code_d  = sel_data;
         ch_d    = gnt_idx;
         if (i_mode) begin
            last_gnt_d = gnt_idx;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q    <= 1'b0;
         code_q     <= '0;
         ch_q       <= '0;
         last_gnt_q <= LAST_CH;
      end else begin
         valid_q    <= valid_d;
         code_q     <= code_d;
         ch_q       <= ch_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   assign o_valid = valid_q;
   assign o_code  = code_q;
   assign o_ch    = ch_q;

endmodule

// File: doc/mux_n_1_arb_v.md
Name: mux_n_1_arb_v

Overview:
- Parametrised, registered N:1 multiplexer with a valid/ready handshake on every input channel and on the output.
- Generalises the combinational 8:1 mux datapath component to any channel count and data width.
- Two select modes:
  - Direct: select comes from a code input.
  - Round-robin: fair arbitration among the channels that are valid.
- Sits between multiple producers and one downstream consumer in the datapath.

Parameters:
- N_CH, 8: number of input channels (2..16).
- DATA_W, 8: width of each channel's data word.
- SEL_W, 3: width of the select/channel-index fields. Must satisfy 2**SEL_W >= N_CH.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_mode  in  1  0 = direct select, 1 = round-robin.
- i_sel_code  in  SEL_W  channel index used in direct mode.
- i_valid  in  N_CH  per-channel valid; bit k belongs to channel k.
- i_data  in  N_CH*DATA_W  flattened channel data; channel k is at [k*DATA_W +: DATA_W].
- o_ready  out  N_CH  per-channel accept (combinational); at most one bit high.
- i_ready  in  1  downstream ready.
- o_valid  out  1  output register holds a word.
- o_code  out  DATA_W  registered output data.
- o_ch  out  SEL_W  index of the channel that supplied o_code.

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_valid=0, o_code=0, o_ch=0.
  - Round-robin pointer last_gnt=N_CH-1, so the first search starts at channel 0.
  - A held word is discarded.
  - Synchronous reset overrides every other event in the same cycle.
- Storage is a single output stage. load_en = !o_valid || i_ready.
- Grant selection (combinational, evaluated every cycle):
  - Direct mode: candidate = i_sel_code. Grant is found only if i_sel_code < N_CH and i_valid[i_sel_code]=1. An out-of-range select means no grant.
  - Round-robin mode: scan channels last_gnt+1, last_gnt+2, ... with wrap at N_CH back to 0. Grant the first channel with i_valid set. If no channel is valid, there is no grant.
- o_ready[k] = grant_found && (gnt_idx==k) && load_en && !i_rst. All other bits are 0.
- Transfer on channel k: i_valid[k] && o_ready[k] at a rising edge. At that edge:
  - o_code <= channel k data, o_ch <= k, o_valid <= 1.
  - In round-robin mode, last_gnt <= k.
- Output consumed (o_valid && i_ready) with no new transfer in the same cycle: o_valid <= 0. o_code and o_ch hold their last values.
- Consume and new transfer in the same cycle: o_valid stays 1 and the register takes the new word. Sustained throughput is 1 word per cycle.
- Latency: 1 cycle from the input transfer edge to o_valid/o_code being visible.
- Back-pressure (o_valid=1 and i_ready=0):
  - o_code, o_ch and o_valid hold stable.
  - o_ready is all 0.
  - The round-robin pointer is frozen.
- last_gnt updates only on a round-robin-mode transfer.
  - Direct-mode transfers leave it unchanged.
  - A mode switch takes effect in the same cycle's grant evaluation, and the pointer is kept across the switch.
- Changing i_sel_code while the output is stalled has no effect on the held word.
- Producers follow the valid/ready rule: data is held stable while valid=1 and ready=0. The block does not check this.
- Data path is pure selection: no arithmetic, no width change.
- Unused upper indices (N_CH..2**SEL_W-1) are never granted.

Test Plan:
- Reset, then defaults, i_ready=1: o_valid=0, o_code=0, o_ch=0, o_ready=0.
- Direct mode, N_CH=8, i_valid=8'hFF, channel k data=8'h10+k, i_sel_code swept 0..7, i_ready=1: one cycle later o_code=8'h10+sel and o_ch=sel each cycle; o_ready has exactly bit sel set.
- Round-robin mode, i_valid=8'b1010_0101, i_ready=1 continuously: grant order 0,2,5,7,0,2,... with one word per cycle and no gaps.
- Back-pressure: with o_code=8'h13 held, i_ready=0 for 4 cycles while all channels are valid:
  - o_code stays 8'h13 and o_ready=0 throughout.
  - When i_ready returns to 1, the next round-robin grant follows channel 3, i.e. channel 4.
- Direct mode with N_CH=5, SEL_W=3, i_sel_code=6, i_valid all 1s: no grant, o_ready=0, o_valid stays 0.
- Reset mid-stream: i_rst high for 1 cycle while o_valid=1 and i_ready=0:
  - Next cycle o_valid=0 and o_code=0.
  - The first round-robin grant after reset is the lowest valid channel, starting the scan from 0.
